// File: rtl/kb_pkg.sv
// kb_pkg -- shared constants for the keyboard receive FIFO.
//
// Holds the CPU register window addresses, the STATUS and CTRL bit positions,
// and a helper that squeezes the FIFO count into the 5-bit STATUS field.
// Imported by kb_buffer and kb_buffer_mem.
package kb_pkg;

  // Register window addresses (io_addr)
  localparam logic [1:0] KB_REG_DATA   = 2'd0;
  localparam logic [1:0] KB_REG_STATUS = 2'd1;
  localparam logic [1:0] KB_REG_CTRL   = 2'd2;
  localparam logic [1:0] KB_REG_PEEK   = 2'd3;

  // STATUS register bit positions
  localparam int KB_STAT_NOT_EMPTY = 0;
  localparam int KB_STAT_FULL      = 1;
  localparam int KB_STAT_OVERFLOW  = 2;
  localparam int KB_STAT_COUNT_LSB = 3;

  // CTRL register bit positions
  localparam int KB_CTRL_FLUSH   = 0;
  localparam int KB_CTRL_CLR_OVF = 1;
  localparam int KB_CTRL_IRQ_EN  = 2;

  // The count field is 5 bits wide; a 64-deep build can hold more than 31
  // bytes, so the reported value saturates instead of wrapping.
  function automatic logic [4:0] kb_sat_count(input logic [6:0] cnt);
    return (cnt > 7'd31) ? 5'd31 : cnt[4:0];
  endfunction

endpackage

// File: rtl/kb_buffer_mem.sv
// kb_buffer_mem -- DEPTH x 8 byte storage for the keyboard FIFO.
//
// Ports:
//   clock    system clock (write on posedge)
//   we       write enable
//   wr_ptr   write address
//   wr_data  byte to store
//   rd_ptr   read address (asynchronous read)
//   rd_data  byte at rd_ptr
//
// Contents are not reset; the pointers in the parent decide what is valid.
module kb_buffer_mem
  import kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_ptr,
  input  logic [7:0]            wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_ptr,
  output logic [7:0]            rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/kb_buffer.sv
// kb_buffer -- receive FIFO between the PS/2 keyboard decoder and the CPU bus.
//
// Each rising edge of kb_done pushes kb_data into a 2^DEPTH_LOG2 byte ring
// buffer. The CPU sees a four-register window:
//   0 DATA   head byte (0x00 when empty); a read pops it
//   1 STATUS {count[4:0], overflow, full, not_empty}
//   2 CTRL   write: bit0 flush, bit1 clear overflow, bit2 irq_en
//            read : {5'b0, irq_en, 2'b0}
//   3 PEEK   head byte without popping
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   kb_done/kb_data decoder strobe and byte
//   io_addr/io_rd/io_wr/io_din  CPU register access
//   io_dout        combinational read data
//   irq            registered level interrupt (irq_en & not_empty)
//
// Build option: define KB_BUFFER_IRQ_EN to implement irq_en and irq; without
// it irq is tied low and CTRL reads as zero.
module kb_buffer
  import kb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kb_done,
  input  logic [7:0] kb_data,
  input  logic [1:0] io_addr,
  input  logic       io_rd,
  input  logic       io_wr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CW-1:0]         CNT_ONE = CW'(1);
  localparam logic [CW-1:0]         CNT_MAX = CW'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  kb_done_q;
  logic                  irq_en;
  logic [7:0]            head;

  logic not_empty;
  logic full;
  logic push_req;
  logic pop_req;
  logic ctrl_wr;
  logic flush;
  logic ovf_clr;
  logic push_ok;
  logic ovf_set;
  logic [4:0] count_sat;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_MAX);

  // A push is the rising edge of kb_done, so a strobe held for many cycles
  // stores its byte only once. Pops on an empty FIFO are simply dropped.
  assign push_req = kb_done & ~kb_done_q;
  assign pop_req  = io_rd & (io_addr == KB_REG_DATA) & not_empty;
  assign ctrl_wr  = io_wr & (io_addr == KB_REG_CTRL);
  assign flush    = ctrl_wr & io_din[KB_CTRL_FLUSH];
  assign ovf_clr  = ctrl_wr & io_din[KB_CTRL_CLR_OVF];

  // When full, a same-cycle pop frees the slot the push needs, so the byte
  // is kept; only a push into a full FIFO with no pop is lost.
  assign push_ok = push_req & (~full | pop_req);
  assign ovf_set = push_req & full & ~pop_req;

  kb_buffer_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clock   (clock),
    .we      (push_ok & ~flush),
    .wr_ptr  (wr_ptr),
    .wr_data (kb_data),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  // Pointer, count and overflow bookkeeping. Flush wins over any push or pop
  // in the same cycle but leaves the overflow flag alone; a same-cycle set
  // and clear of overflow resolves to set.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      kb_done_q <= 1'b0;
    end else begin
      kb_done_q <= kb_done;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_req) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push_ok && !pop_req) begin
          count <= count + CNT_ONE;
        end else if (!push_ok && pop_req) begin
          count <= count - CNT_ONE;
        end
      end
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef KB_BUFFER_IRQ_EN
  logic irq_q;

  // irq follows the registered enable and occupancy, so it lags a push or
  // the emptying pop by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= io_din[KB_CTRL_IRQ_EN];
      end
      irq_q <= irq_en & not_empty;
    end
  end

  assign irq = irq_q;
  wire unused_din = ^io_din[7:3];
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
  wire unused_din = ^io_din[7:2];
`endif

  assign count_sat = kb_sat_count(7'(count));

  // Register read mux; DATA and PEEK show 0x00 rather than stale memory
  // when nothing is buffered.
  always_comb begin
    io_dout = 8'h00;
    case (io_addr)
      KB_REG_DATA,
      KB_REG_PEEK: begin
        io_dout = not_empty ? head : 8'h00;
      end
      KB_REG_STATUS: begin
        io_dout[KB_STAT_NOT_EMPTY] = not_empty;
        io_dout[KB_STAT_FULL]      = full;
        io_dout[KB_STAT_OVERFLOW]  = overflow;
        io_dout[7:KB_STAT_COUNT_LSB] = count_sat;
      end
      KB_REG_CTRL: begin
        io_dout[KB_CTRL_IRQ_EN] = irq_en;
      end
      default: begin
        io_dout = 8'h00;
      end
    endcase
  end

endmodule
